// File: rtl/cpu_defs.sv
// Shared RV32I front-end definitions: datapath width, bubble instruction and opcodes.
package cpu_defs;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 7;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory port between the fetch stage (master) and instruction memory (slave).
interface if_stage_if;
  import cpu_defs::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;

  modport master (output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/pc_reg.sv
// Program counter with next-PC select: aligned redirect target, +4 advance, or hold.
module pc_reg
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_target,
  input  logic            advance,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_nxt_c;

  // Redirect wins over sequential advance; otherwise hold.
  always_comb begin
    pc_nxt_c = pc;
    if (load_target) begin
      pc_nxt_c = target;
    end else if (advance) begin
      pc_nxt_c = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt_c;
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, instruction-memory address and the IF/ID register.
module if_stage #(
  parameter logic [cpu_defs::XLEN-1:0] RESET_PC  = '0,
  parameter logic [cpu_defs::XLEN-1:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        redirect,
  input  logic [cpu_defs::XLEN-1:0]   redirect_pc,
  if_stage_if.master                  imem,
  output logic                        id_valid,
  output logic [cpu_defs::XLEN-1:0]   id_pc,
  output logic [cpu_defs::XLEN-1:0]   id_instr,
  output logic [6:0]                  id_op,
  output logic [2:0]                  id_funct3,
  output logic [6:0]                  id_funct7,
  output logic                        misalign_err
);

  localparam int unsigned XLEN = cpu_defs::XLEN;

  logic [XLEN-1:0] pc;
  logic            fetch_c;
  logic [XLEN-1:0] target_c;

  assign fetch_c  = !redirect && !stall && imem.imem_ready;
  assign target_c = {redirect_pc[XLEN-1:2], 2'b00};

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .load_target (redirect),
    .advance     (fetch_c),
    .target      (target_c),
    .pc          (pc)
  );

  assign imem.imem_addr = pc;

  // IF/ID register: flush on redirect, freeze on stall, bubble on wait, else capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_instr     <= NOP_INSTR;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect && (|redirect_pc[1:0]);
      if (redirect) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else if (stall) begin
        id_valid <= id_valid;
      end else if (!imem.imem_ready) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_instr <= imem.imem_rdata;
      end
    end
  end

  // Decoder fields are straight slices of the registered instruction.
  assign id_op     = id_instr[6:0];
  assign id_funct3 = id_instr[14:12];
  assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic against a reference model.
module tb_if_stage;
  import cpu_defs::*;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Synthetic instruction memory: every word is a fixed function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'(a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // DUT 0: default reset PC
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        id_valid, misalign_err;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  id_op, id_funct7;
  logic [2:0]  id_funct3;

  if_stage_if tif ();
  assign tif.imem_rdata = mem_word(tif.imem_addr);

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem         (tif),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_instr     (id_instr),
    .id_op        (id_op),
    .id_funct3    (id_funct3),
    .id_funct7    (id_funct7),
    .misalign_err (misalign_err)
  );

  // DUT 1: reset PC near the top of the address space
  logic        rst1;
  logic        stall1 = 1'b0;
  logic        redirect1 = 1'b0;
  logic [31:0] redirect_pc1 = '0;
  logic        id_valid1, misalign_err1;
  logic [31:0] id_pc1, id_instr1;
  logic [6:0]  id_op1, id_funct71;
  logic [2:0]  id_funct31;

  if_stage_if tif1 ();
  assign tif1.imem_rdata = mem_word(tif1.imem_addr);

  if_stage #(.RESET_PC(WRAP_PC)) dut1 (
    .clk          (clk),
    .rst          (rst1),
    .stall        (stall1),
    .redirect     (redirect1),
    .redirect_pc  (redirect_pc1),
    .imem         (tif1),
    .id_valid     (id_valid1),
    .id_pc        (id_pc1),
    .id_instr     (id_instr1),
    .id_op        (id_op1),
    .id_funct3    (id_funct31),
    .id_funct7    (id_funct71),
    .misalign_err (misalign_err1)
  );

  // Reference model of DUT 0, advanced on every rising edge from the sampled inputs.
  logic [31:0] m_pc, m_ipc, m_ins;
  logic        m_v, m_mis;
  bit          seen_rst = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_ins = NOP_INSTR; m_mis = 1'b0;
      seen_rst = 1'b1;
    end else begin
      m_mis = redirect && (redirect_pc % 4 != 0);
      if (redirect) begin
        m_pc = redirect_pc - (redirect_pc % 4);
        m_v = 1'b0; m_ins = NOP_INSTR;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (!tif.imem_ready) begin
        m_v = 1'b0; m_ins = NOP_INSTR;
      end else begin
        m_ins = mem_word(m_pc); m_ipc = m_pc; m_v = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    if (seen_rst) begin
      check("imem_addr", tif.imem_addr, m_pc);
      check("id_valid", 32'(id_valid), 32'(m_v));
      check("id_pc", id_pc, m_ipc);
      check("id_instr", id_instr, m_ins);
      check("id_op", 32'(id_op), 32'(m_ins[6:0]));
      check("id_funct3", 32'(id_funct3), 32'(m_ins[14:12]));
      check("id_funct7", 32'(id_funct7), 32'(m_ins[31:25]));
      check("misalign_err", 32'(misalign_err), 32'(m_mis));
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tif.imem_ready = 1'b1;
    rst1 = 1'b1; tif1.imem_ready = 1'b1;
    repeat (3) step();
    check("rst addr", tif.imem_addr, 32'h0);
    check("rst valid", 32'(id_valid), 32'h0);
    check("rst instr", id_instr, 32'h13);
    check("rst op", 32'(id_op), 32'(OP_ITYPE));

    rst = 1'b0;
    step();
    check("first pc", id_pc, 32'h0);
    check("first instr", id_instr, mem_word(32'h0));
    check("first valid", 32'(id_valid), 32'h1);
    step();
    check("second pc", id_pc, 32'h4);
    check("second addr", tif.imem_addr, 32'h8);

    stall = 1'b1;
    repeat (3) begin
      tif.imem_ready = 1'($urandom_range(0, 1));
      step();
      check("stall pc", id_pc, 32'h4);
      check("stall instr", id_instr, mem_word(32'h4));
      check("stall addr", tif.imem_addr, 32'h8);
    end

    stall = 1'b0; tif.imem_ready = 1'b0;
    repeat (2) begin
      step();
      check("wait addr", tif.imem_addr, 32'h8);
      check("wait valid", 32'(id_valid), 32'h0);
    end
    tif.imem_ready = 1'b1;
    step();
    check("after wait pc", id_pc, 32'h8);
    check("after wait instr", id_instr, mem_word(32'h8));

    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    check("redir addr", tif.imem_addr, 32'h40);
    check("redir valid", 32'(id_valid), 32'h0);
    redirect = 1'b0; stall = 1'b0;
    step();
    check("redir id_pc", id_pc, 32'h40);

    redirect = 1'b1; redirect_pc = 32'h46;
    step();
    check("misalign addr", tif.imem_addr, 32'h44);
    check("misalign high", 32'(misalign_err), 32'h1);
    redirect = 1'b0;
    step();
    check("misalign low", 32'(misalign_err), 32'h0);

    for (int i = 0; i < 500; i++) begin
      rst            = ($urandom_range(0, 99) < 2);
      redirect       = ($urandom_range(0, 99) < 10);
      redirect_pc    = 32'($urandom_range(0, 255));
      stall          = ($urandom_range(0, 99) < 20);
      tif.imem_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    rst = 1'b0; redirect = 1'b0; stall = 1'b0; tif.imem_ready = 1'b1;
    repeat (3) step();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
    step();
    check("midrst addr", tif.imem_addr, 32'h0);
    check("midrst valid", 32'(id_valid), 32'h0);
    check("midrst instr", id_instr, 32'h13);
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    step();
    check("midrst first pc", id_pc, 32'h0);

    check("wrap rst addr", tif1.imem_addr, WRAP_PC);
    rst1 = 1'b0;
    step();
    check("wrap pc0", id_pc1, 32'hFFFF_FFF8);
    step();
    check("wrap pc1", id_pc1, 32'hFFFF_FFFC);
    step();
    check("wrap pc2", id_pc1, 32'h0000_0000);
    check("wrap addr", tif1.imem_addr, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
